// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/issue controller for the single-cycle
// R-type datapath. Fetches words over a req/valid handshake, holds them in an
// instruction register, pulses dp_we once per legal ADD/SUB and stops on EBREAK.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal words halt instead of skip).
module instr_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [31:0]      dp_instr,
    output logic             dp_we,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [31:0] EBREAK = 32'h00100073;

    state_t           state, state_n;
    logic [PC_W-1:0]  pc, pc_n;
    logic [31:0]      ir, ir_n;
    logic [CNT_W-1:0] retired_n;
    logic             illegal_n;
    logic             ir_legal;
    logic             ir_ebreak;

    // Decode of the held instruction: only R-type ADD/SUB are issued.
    always_comb begin
        ir_legal  = (ir[6:0] == 7'b0110011) && (ir[14:12] == 3'b000) &&
                    ((ir[31:25] == 7'b0000000) || (ir[31:25] == 7'b0100000));
        ir_ebreak = (ir == EBREAK);
    end

    // State and datapath-facing registers; reset abandons any fetch in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            retired <= '0;
            illegal <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            ir      <= ir_n;
            retired <= retired_n;
            illegal <= illegal_n;
        end
    end

    // Next-state and output decode; outputs depend only on registered state/ir.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        retired_n = retired;
        illegal_n = illegal;
        imem_req  = 1'b0;
        dp_we     = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_n      = RESET_PC;
                    retired_n = '0;
                    illegal_n = 1'b0;
                    state_n   = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_n      = RESET_PC;
                    retired_n = '0;
                    illegal_n = 1'b0;
                    state_n   = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_valid) begin
                    ir_n    = imem_rdata;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                if (ir_legal) begin
                    dp_we     = 1'b1;
                    retired_n = retired + CNT_W'(1);
                    pc_n      = pc + PC_W'(4);
                    state_n   = S_FETCH;
                end else if (ir_ebreak) begin
                    state_n = S_HALT;
                end else begin
                    illegal_n = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    state_n   = S_HALT;
`else
                    pc_n      = pc + PC_W'(4);
                    state_n   = S_FETCH;
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign dp_instr  = ir;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: self-checking bench for instr_sequencer with a
// variable-latency instruction memory, a behavioural register-file datapath
// and an instruction-level reference model of the program run.
module tb_instr_sequencer;

    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] dp_instr;
    logic        dp_we;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [64];
    int          mem_lat = 0;
    int          wait_cnt;
    logic        force_valid = 1'b0;

    logic [31:0] regs [32];
    logic [31:0] regs_init [32];

    logic [31:0] exp_instr [$];
    int          exp_pc [$];
    int          exp_idx [$];
    int          m_pc;
    int          m_ret;
    bit          m_ill;
    logic [31:0] m_regs [32];

    instr_sequencer #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dp_instr(dp_instr), .dp_we(dp_we), .busy(busy), .halted(halted),
        .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Memory: valid comes mem_lat cycles after the first request cycle.
    assign imem_rdata = mem[imem_addr[7:2]];
    assign imem_valid = (imem_req && (wait_cnt == mem_lat)) || force_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    function automatic logic [31:0] rtype(input bit sub, input int rs2, input int rs1, input int rd);
        logic [4:0] a, b, d;
        a = 5'(rs1); b = 5'(rs2); d = 5'(rd);
        return {sub ? 7'b0100000 : 7'b0000000, b, a, 3'b000, d, 7'b0110011};
    endfunction

    function automatic bit is_legal(input logic [31:0] w);
        return (w[6:0] == 7'b0110011) && (w[14:12] == 3'b000) &&
               ((w[31:25] == 7'b0000000) || (w[31:25] == 7'b0100000));
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        return (w[31:25] == 7'b0100000) ? a - b : a + b;
    endfunction

    task automatic preload_regs();
        for (int i = 0; i < 32; i++) regs_init[i] = 32'h0;
        regs_init[1] = 32'd10;
        regs_init[2] = 32'd20;
        for (int i = 0; i < 32; i++) regs[i] = regs_init[i];
    endtask

    // Instruction-level reference: walk the program by the ISA rules.
    task automatic model();
        int  pc;
        int  rd;
        bit  done;
        logic [31:0] w;
        exp_instr.delete(); exp_pc.delete(); exp_idx.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = regs_init[i];
        pc = 0; m_ret = 0; m_ill = 0; done = 0;
        for (int step = 0; step < 256 && !done; step++) begin
            w = mem[pc / 4];
            if (is_legal(w)) begin
                exp_instr.push_back(w); exp_pc.push_back(pc); exp_idx.push_back(step);
                rd = int'(w[11:7]);
                if (rd != 0) m_regs[rd] = alu(w, m_regs[w[19:15]], m_regs[w[24:20]]);
                m_ret++;
                pc = (pc + 4) % 256;
            end else if (w == EBREAK) begin
                done = 1;
            end else begin
                m_ill = 1;
`ifdef ILLEGAL_TRAP_EN
                done = 1;
`else
                pc = (pc + 4) % 256;
`endif
            end
        end
        m_pc = pc;
    endtask

    task automatic fill_mem(input logic [31:0] w);
        for (int i = 0; i < 64; i++) mem[i] = w;
    endtask

    // Run the loaded program from IDLE/HALT and compare against the model.
    task automatic run_prog(input string name, input int lat, input bit noise);
        int cyc, pulses, req_run, budget;
        logic [7:0] prev_addr;
        bit prev_req;
        mem_lat = lat;
        preload_regs();
        model();
        budget = (m_ret + 40) * (lat + 2) + 600;
        cyc = 0; pulses = 0; req_run = 0; prev_req = 0; prev_addr = '0;
        @(negedge clk); start = 1'b1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (noise && busy && ($urandom_range(0, 2) == 0)) ? 1'b1 : 1'b0;
            if (halted) break;
            if (imem_req) begin
                if (prev_req) begin
                    checks++;
                    if (imem_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL %s addr_stable: got %h want %h", name, imem_addr, prev_addr);
                    end
                end
                req_run++;
                if (imem_valid) begin
                    checks++;
                    if (req_run !== lat + 1) begin
                        errors++;
                        $display("FAIL %s req_len: got %0d want %0d", name, req_run, lat + 1);
                    end
                    req_run = 0;
                end
            end
            prev_req = imem_req;
            prev_addr = imem_addr;
            if (dp_we) begin
                checks++;
                if (pulses >= exp_instr.size()) begin
                    errors++;
                    $display("FAIL %s extra_we: got pulse %0d want %0d pulses", name, pulses, exp_instr.size());
                end else begin
                    if (dp_instr !== exp_instr[pulses] || imem_addr !== 8'(exp_pc[pulses]) ||
                        retired !== 16'(pulses) || cyc !== (exp_idx[pulses] + 1) * (lat + 2)) begin
                        errors++;
                        $display("FAIL %s issue%0d: got instr=%h pc=%h ret=%0d cyc=%0d want instr=%h pc=%h ret=%0d cyc=%0d",
                                 name, pulses, dp_instr, imem_addr, retired, cyc, exp_instr[pulses],
                                 8'(exp_pc[pulses]), pulses, (exp_idx[pulses] + 1) * (lat + 2));
                    end
                    if (dp_instr[11:7] != 5'd0)
                        regs[dp_instr[11:7]] = alu(dp_instr, regs[dp_instr[19:15]], regs[dp_instr[24:20]]);
                end
                pulses++;
            end
        end
        start = 1'b0;
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s halt: got halted=%b busy=%b want halted=1 busy=0", name, halted, busy);
        end
        checks++;
        if (imem_addr !== 8'(m_pc) || retired !== 16'(m_ret) || illegal !== m_ill || pulses !== exp_instr.size()) begin
            errors++;
            $display("FAIL %s final: got pc=%h ret=%0d ill=%b pulses=%0d want pc=%h ret=%0d ill=%b pulses=%0d",
                     name, imem_addr, retired, illegal, pulses, 8'(m_pc), m_ret, m_ill, exp_instr.size());
        end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (regs[i] !== m_regs[i]) begin
                errors++;
                $display("FAIL %s regs[%0d]: got %0d want %0d", name, i, regs[i], m_regs[i]);
            end
        end
    endtask

    task automatic load_prog1();
        fill_mem(EBREAK);
        mem[0] = rtype(0, 2, 1, 3);
        mem[1] = rtype(1, 1, 2, 4);
        mem[2] = EBREAK;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_req, dp_we, busy, halted, illegal} !== 5'b0 || retired !== 16'h0 ||
            dp_instr !== 32'h0 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got req=%b we=%b busy=%b halt=%b ill=%b ret=%0d instr=%h pc=%h want all zero",
                     imem_req, dp_we, busy, halted, illegal, retired, dp_instr, imem_addr);
        end
    endtask

    task automatic test_basic();
        load_prog1();
        run_prog("basic", 0, 0);
        checks++;
        if (regs[3] !== 32'd30 || regs[4] !== 32'd10) begin
            errors++;
            $display("FAIL basic_regs: got x3=%0d x4=%0d want x3=30 x4=10", regs[3], regs[4]);
        end
    endtask

    task automatic test_restart();
        load_prog1();
        run_prog("restart", 0, 1);
    endtask

    task automatic test_illegal();
        fill_mem(EBREAK);
        mem[0] = rtype(0, 2, 1, 3);
        mem[1] = 32'h00528283;
        mem[2] = EBREAK;
        run_prog("illegal", 0, 0);
        checks++;
`ifdef ILLEGAL_TRAP_EN
        if (imem_addr !== 8'h04 || illegal !== 1'b1 || retired !== 16'd1 || regs[5] !== 32'd0) begin
`else
        if (imem_addr !== 8'h08 || illegal !== 1'b1 || retired !== 16'd1 || regs[5] !== 32'd0) begin
`endif
            errors++;
            $display("FAIL illegal_final: got pc=%h ill=%b ret=%0d x5=%0d", imem_addr, illegal, retired, regs[5]);
        end
    endtask

    task automatic test_latency();
        load_prog1();
        run_prog("latency", 3, 0);
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        bit seen;
        load_prog1();
        mem_lat = 3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (dp_we) seen = 1;
        end
        @(negedge clk);
        checks++;
        if (!seen || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got we_seen=%b req=%b want 1 1", seen, imem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, dp_we, busy, halted, illegal} !== 5'b0 || retired !== 16'h0 ||
            dp_instr !== 32'h0 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: got req=%b we=%b busy=%b halt=%b ill=%b ret=%0d instr=%h pc=%h want all zero",
                     imem_req, dp_we, busy, halted, illegal, retired, dp_instr, imem_addr);
        end
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL rst_idle: got busy=%b halt=%b req=%b want 0 0 0", busy, halted, imem_req);
            end
        end
        force_valid = 1'b1;
        @(negedge clk); force_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dp_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL late_valid: got we=%b busy=%b want 0 0", dp_we, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pc_wrap();
        int pulses;
        fill_mem(rtype(0, 2, 1, 3));
        mem_lat = 0;
        pulses = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 400 && pulses < 70; c++) begin
            if (dp_we) begin
                checks++;
                if (imem_addr !== 8'(4 * pulses) || retired !== 16'(pulses) || dp_instr !== mem[0]) begin
                    errors++;
                    $display("FAIL wrap%0d: got pc=%h ret=%0d instr=%h want pc=%h ret=%0d instr=%h",
                             pulses, imem_addr, retired, dp_instr, 8'(4 * pulses), pulses, mem[0]);
                end
                pulses++;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 70) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 70", pulses);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random();
        int n, kind;
        logic [31:0] w;
        for (int t = 0; t < 8; t++) begin
            fill_mem(EBREAK);
            n = $urandom_range(3, 14);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 5);
                w = rtype(($urandom_range(0, 1) == 1), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31));
                if (kind == 0) w = {w[31:7], 7'b0000011};
                else if (kind == 1) w[14:12] = 3'(($urandom_range(1, 7)));
                else if (kind == 2) w[31:25] = 7'b0100001;
                mem[i] = w;
            end
            run_prog("random", $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_illegal();
        test_latency();
        test_reset_mid_fetch();
        test_pc_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
